lut_window_gen: RTL and testbench

LUT_WINDOW_GEN -- requirements
Module: lut_window_gen

---
 rtl/lut_pkg.sv | 21 ++
 rtl/lut_line_buf.sv | 32 +++
 rtl/lut_window_gen.sv | 221 ++++++++++++++++++++++
 tb/tb_lut_window_gen.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lut_pkg.sv
// Shared definitions for the 3x3 window generator that feeds the LUT stage.
// Holds default frame geometry, the address split of an 8-bit pixel into
// MSB/LSB fields, the kernel size, the packed window type and FSM states.
package lut_pkg;

    localparam int IMG_W_DEF    = 50;
    localparam int IMG_H_DEF    = 50;
    localparam int MSB_BITS_DEF = 6;
    localparam int LSB_BITS_DEF = 8 - MSB_BITS_DEF;
    localparam int K            = 3;

    // Window element i is row (i / K), column (i % K); element 0 is top-left.
    typedef logic [K*K-1:0][7:0] win_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/lut_line_buf.sv
// One image row of delay: an 8-bit shift line that advances only when
// i_en is high, so o_data is the pixel accepted DEPTH enables earlier.
// Ports:
//   clk    - clock
//   i_en   - shift enable (one pixel accepted)
//   i_data - pixel entering the line
//   o_data - pixel leaving the line (same column, previous row)
module lut_line_buf #(
    parameter int DEPTH = 50
) (
    input  logic       clk,
    input  logic       i_en,
    input  logic [7:0] i_data,
    output logic [7:0] o_data
);

    logic [7:0] r_line [DEPTH];

    // Contents are deliberately not reset: two full rows of a new frame are
    // always shifted in before any window built from this line is emitted.
    always_ff @(posedge clk) begin
        if (i_en) begin
            r_line[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_line[i] <= r_line[i-1];
            end
        end
    end

    assign o_data = r_line[DEPTH-1];

endmodule

// File: rtl/lut_window_gen.sv
// Raster-order pixel stream to 3x3 window stream for a LUT lookup stage.
// Two line buffers supply the two rows above the incoming pixel; a 3x3
// shift register holds the window, which doubles as the output register.
// Ports:
//   clk, rst           - clock, asynchronous active-high reset
//   s_valid/s_ready    - input pixel handshake; s_data pixel, s_sof frame start
//   m_valid/m_ready    - output window handshake
//   m_win              - 3x3 window, index 0 top-left, row-major
//   m_msb/m_lsb        - per-element high/low address fields of m_win
//   m_x/m_y            - window coordinate (top-left pixel of the window)
//   m_last             - final window of the frame
//   err_sof            - sticky flag: a frame start arrived mid-frame
module lut_window_gen
    import lut_pkg::*;
#(
    parameter int IMG_W    = IMG_W_DEF,
    parameter int IMG_H    = IMG_H_DEF,
    parameter int MSB_BITS = MSB_BITS_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [7:0]                 s_data,
    input  logic                       s_sof,
    output logic                       m_valid,
    input  logic                       m_ready,
    output win_t                       m_win,
    output logic [8:0][MSB_BITS-1:0]   m_msb,
    output logic [8:0][7-MSB_BITS:0]   m_lsb,
    output logic [7:0]                 m_x,
    output logic [7:0]                 m_y,
    output logic                       m_last,
    output logic                       err_sof
);

    localparam logic [7:0] LAST_COL = 8'(IMG_W - 1);
    localparam logic [7:0] LAST_ROW = 8'(IMG_H - 1);

    state_t     r_state;
    state_t     w_nextState;
    logic [7:0] r_col;
    logic [7:0] r_row;
    logic [7:0] w_pixCol;
    logic [7:0] w_pixRow;
    logic [7:0] w_nextCol;
    logic [7:0] w_nextRow;
    logic       w_sReady;
    logic       w_accept;
    logic       w_process;
    logic       w_restart;
    logic       w_frameEnd;
    logic       w_produce;
    logic [7:0] w_lb0Out;
    logic [7:0] w_lb1Out;
    logic       r_mValid;
    logic       r_last;
    logic       r_errSof;
    logic [7:0] r_x;
    logic [7:0] r_y;
    win_t       r_win;

    // Row above (lb0) and two rows above (lb1) the incoming pixel.
    lut_line_buf #(.DEPTH(IMG_W)) u_lb0 (
        .clk    (clk),
        .i_en   (w_process),
        .i_data (s_data),
        .o_data (w_lb0Out)
    );

    lut_line_buf #(.DEPTH(IMG_W)) u_lb1 (
        .clk    (clk),
        .i_en   (w_process),
        .i_data (w_lb0Out),
        .o_data (w_lb1Out)
    );

    // Frame state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and handshake decode. A pixel is "processed" when it enters
    // the frame: a SOF pixel in any accepting state, or any pixel in ACTIVE.
    // A SOF pixel always restarts the raster position at (0,0). The output
    // register is the window itself, so input is accepted only when that
    // register is free or being drained this cycle.
    always_comb begin
        w_nextState = r_state;
        w_process   = 1'b0;
        w_restart   = 1'b0;
        w_sReady    = !rst && (r_state != ST_DONE) && (!r_mValid || m_ready);
        w_accept    = s_valid && w_sReady;

        case (r_state)
            ST_IDLE: begin
                if (w_accept && s_sof) begin
                    w_process   = 1'b1;
                    w_restart   = 1'b1;
                    w_nextState = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (w_accept) begin
                    w_process = 1'b1;
                    w_restart = s_sof;
                end
            end
            ST_DONE: begin
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase

        w_pixCol   = w_restart ? 8'd0 : r_col;
        w_pixRow   = w_restart ? 8'd0 : r_row;
        w_frameEnd = w_process && (w_pixRow == LAST_ROW) && (w_pixCol == LAST_COL);
        w_produce  = w_process && (w_pixRow >= 8'd2) && (w_pixCol >= 8'd2);

        if (w_frameEnd) begin
            w_nextState = ST_DONE;
        end

        if (w_frameEnd) begin
            w_nextCol = 8'd0;
            w_nextRow = 8'd0;
        end else if (w_pixCol == LAST_COL) begin
            w_nextCol = 8'd0;
            w_nextRow = w_pixRow + 8'd1;
        end else begin
            w_nextCol = w_pixCol + 8'd1;
            w_nextRow = w_pixRow;
        end
    end

    // Raster position of the next expected pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= 8'd0;
            r_row <= 8'd0;
        end else if (w_process) begin
            r_col <= w_nextCol;
            r_row <= w_nextRow;
        end
    end

    // Window shift register: each row shifts left and takes its new right
    // column from the matching source. Because only three pixels of the
    // current row have entered by column 2, a window never mixes rows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win <= '0;
        end else if (w_process) begin
            r_win[0] <= r_win[1];
            r_win[1] <= r_win[2];
            r_win[2] <= w_lb1Out;
            r_win[3] <= r_win[4];
            r_win[4] <= r_win[5];
            r_win[5] <= w_lb0Out;
            r_win[6] <= r_win[7];
            r_win[7] <= r_win[8];
            r_win[8] <= s_data;
        end
    end

    // Output qualifiers. A consumed window drops valid and last; a new
    // window overrides that in the same cycle, giving full throughput.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mValid <= 1'b0;
            r_last   <= 1'b0;
            r_x      <= 8'd0;
            r_y      <= 8'd0;
        end else begin
            if (r_mValid && m_ready) begin
                r_mValid <= 1'b0;
                r_last   <= 1'b0;
            end
            if (w_produce) begin
                r_mValid <= 1'b1;
                r_last   <= w_frameEnd;
                r_x      <= w_pixCol - 8'd2;
                r_y      <= w_pixRow - 8'd2;
            end
        end
    end

    // Sticky record of a frame start seen while a frame was in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_errSof <= 1'b0;
        end else if (w_restart && (r_state == ST_ACTIVE)) begin
            r_errSof <= 1'b1;
        end
    end

    // Split every window element into its LUT address fields.
    always_comb begin
        m_msb = '0;
        m_lsb = '0;
        for (int i = 0; i < K*K; i++) begin
            m_msb[i] = r_win[i][7 -: MSB_BITS];
            m_lsb[i] = r_win[i][7-MSB_BITS:0];
        end
    end

    assign s_ready = w_sReady;
    assign m_valid = r_mValid;
    assign m_win   = r_win;
    assign m_x     = r_x;
    assign m_y     = r_y;
    assign m_last  = r_last;
    assign err_sof = r_errSof;

endmodule

// File: tb/tb_lut_window_gen.sv
// Scoreboard bench for lut_window_gen: a frame-array reference model pushes
// expected windows as pixels are accepted; a monitor compares every cycle
// the DUT presents a window and pops on each handshake.
module tb_lut_window_gen;

    localparam int W      = 50;
    localparam int H      = 50;
    localparam int MSB_W  = 6;
    localparam int LSB_W  = 8 - MSB_W;
    localparam int EXP_WINS = (W - 2) * (H - 2);

    typedef struct packed {
        logic [8:0][7:0] win;
        logic [7:0]      x;
        logic [7:0]      y;
        logic            last;
    } exp_t;

    logic                   clk;
    logic                   rst;
    logic                   s_valid;
    logic                   s_ready;
    logic [7:0]             s_data;
    logic                   s_sof;
    logic                   m_valid;
    logic                   m_ready;
    logic [8:0][7:0]        m_win;
    logic [8:0][MSB_W-1:0]  m_msb;
    logic [8:0][LSB_W-1:0]  m_lsb;
    logic [7:0]             m_x;
    logic [7:0]             m_y;
    logic                   m_last;
    logic                   err_sof;

    int   nChecks = 0;
    int   nPass   = 0;
    int   winCount = 0;
    int   mProduced = 0;
    int   readyMode = 0;
    int   readyCnt = 0;
    bit   rampMode = 0;
    exp_t expQ[$];

    logic [7:0] img [H][W];
    bit         mActive = 0;
    int         mRow = 0;
    int         mCol = 0;
    bit         expErr = 0;
    bit         frameDone = 0;

    lut_window_gen #(.IMG_W(W), .IMG_H(H), .MSB_BITS(MSB_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_sof   (s_sof),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_win   (m_win),
        .m_msb   (m_msb),
        .m_lsb   (m_lsb),
        .m_x     (m_x),
        .m_y     (m_y),
        .m_last  (m_last),
        .err_sof (err_sof)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void checkOutput(string name, logic [71:0] act, logic [71:0] exp);
        nChecks++;
        if (act === exp) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    // Reference model: keeps the whole frame as a 2-D array and forms each
    // window directly from the 3x3 neighbourhood ending at the new pixel.
    function automatic void modelAccept(logic [7:0] d, bit sof);
        exp_t e;
        if (!mActive && !sof) return;
        if (sof) begin
            if (mActive) expErr = 1'b1;
            mActive = 1'b1;
            mRow = 0;
            mCol = 0;
        end
        img[mRow][mCol] = d;
        if (mRow >= 2 && mCol >= 2) begin
            for (int dr = 0; dr < 3; dr++) begin
                for (int dc = 0; dc < 3; dc++) begin
                    e.win[dr*3+dc] = img[mRow-2+dr][mCol-2+dc];
                end
            end
            e.x    = 8'(mCol - 2);
            e.y    = 8'(mRow - 2);
            e.last = (mRow == H-1) && (mCol == W-1);
            expQ.push_back(e);
            mProduced++;
        end
        mCol++;
        if (mCol == W) begin
            mCol = 0;
            mRow++;
            if (mRow == H) begin
                mActive = 1'b0;
                frameDone = 1'b1;
            end
        end
    endfunction

    task automatic applyStimulus(input logic [7:0] d, input bit sof);
        int guard;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        s_sof   = sof;
        #1;
        guard = 0;
        while (!s_ready && guard < 200) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!s_ready) begin
            nChecks++;
            $display("[TB] FAIL acceptTimeout: s_ready got 0, expected 1 within 200 cycles");
            $fatal(1, "[TB] input stalled");
        end
        modelAccept(d, sof);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    task automatic sendFrame(input int nPix, input bit ramp, input bit gaps);
        logic [7:0] d;
        for (int k = 0; k < nPix; k++) begin
            if (gaps && $urandom_range(0, 7) == 0) @(negedge clk);
            d = ramp ? 8'(k % 256) : 8'($urandom);
            frameDone = 1'b0;
            applyStimulus(d, k == 0);
        end
        if (frameDone) begin
            @(negedge clk);
            #1;
            checkOutput("doneNotReady", 72'(s_ready), 72'(0));
        end
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (expQ.size() != 0) begin
            nChecks++;
            $display("[TB] FAIL drainTimeout: %0d windows outstanding, expected 0", expQ.size());
            expQ.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // Monitor: drive m_ready, then compare any presented window to the
    // head of the scoreboard; pop only when the handshake will complete.
    initial begin : monitor
        exp_t e;
        logic [8:0][MSB_W-1:0] expMsb;
        logic [8:0][LSB_W-1:0] expLsb;
        logic [8:0][7:0]       firstWin;
        for (int i = 0; i < 9; i++) firstWin[i] = 8'((i / 3) * W + (i % 3));
        m_ready = 1'b1;
        forever begin
            @(negedge clk);
            readyCnt++;
            if (readyMode == 1)      m_ready = (readyCnt % 3 == 0);
            else if (readyMode == 2) m_ready = ($urandom_range(0, 1) == 1);
            else                     m_ready = 1'b1;
            #2;
            if (m_valid) begin
                if (expQ.size() == 0) begin
                    nChecks++;
                    $display("[TB] FAIL extraWindow: got window x=%0d y=%0d, expected none", m_x, m_y);
                end else begin
                    e = expQ[0];
                    for (int i = 0; i < 9; i++) begin
                        expMsb[i] = MSB_W'(e.win[i] >> LSB_W);
                        expLsb[i] = LSB_W'(e.win[i] % (1 << LSB_W));
                    end
                    checkOutput("win",  72'(m_win), 72'(e.win));
                    checkOutput("msb",  72'(m_msb), 72'(expMsb));
                    checkOutput("lsb",  72'(m_lsb), 72'(expLsb));
                    checkOutput("x",    72'(m_x),   72'(e.x));
                    checkOutput("y",    72'(m_y),   72'(e.y));
                    checkOutput("last", 72'(m_last), 72'(e.last));
                    if (rampMode && e.x == 8'd0 && e.y == 8'd0) begin
                        checkOutput("rampFirstWin", 72'(m_win), 72'(firstWin));
                    end
                    if (rampMode && e.x == 8'd32 && e.y == 8'd2) begin
                        checkOutput("centreMsb", 72'(m_msb[4]), 72'(6'b101101));
                        checkOutput("centreLsb", 72'(m_lsb[4]), 72'(2'b11));
                    end
                    if (m_ready) begin
                        void'(expQ.pop_front());
                        winCount++;
                    end
                end
            end
        end
    end

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = 8'd0;
        s_sof   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstReady",  72'(s_ready), 72'(0));
        checkOutput("rstValid",  72'(m_valid), 72'(0));
        checkOutput("rstLast",   72'(m_last),  72'(0));
        checkOutput("rstErr",    72'(err_sof), 72'(0));
        checkOutput("rstWin",    72'(m_win),   72'(0));
        checkOutput("rstXY",     72'({m_x, m_y}), 72'(0));
        @(negedge clk);
        #3 rst = 1'b0;
        #1 checkOutput("readyAfterRst", 72'(s_ready), 72'(1));

        $display("[TB] ramp frame, full throughput");
        rampMode = 1; readyMode = 0; winCount = 0; mProduced = 0;
        sendFrame(W*H, 1'b1, 1'b0);
        waitDrain();
        rampMode = 0;
        checkOutput("rampCount", 72'(winCount), 72'(EXP_WINS));
        checkOutput("rampErr",   72'(err_sof),  72'(0));

        $display("[TB] pixels without sof while idle");
        winCount = 0;
        for (int k = 0; k < 30; k++) applyStimulus(8'($urandom), 1'b0);
        waitDrain();
        checkOutput("idleNoOutput", 72'(winCount), 72'(0));

        $display("[TB] random frame, m_ready 1 of 3");
        readyMode = 1; winCount = 0; mProduced = 0;
        sendFrame(W*H, 1'b0, 1'b1);
        waitDrain();
        checkOutput("stallCount", 72'(winCount), 72'(EXP_WINS));

        $display("[TB] sof at row 10 col 5");
        readyMode = 2; winCount = 0; mProduced = 0;
        sendFrame(10*W + 5, 1'b0, 1'b1);
        sendFrame(W*H, 1'b0, 1'b1);
        waitDrain();
        checkOutput("abortCount", 72'(winCount), 72'(mProduced));
        checkOutput("abortProduced", 72'(mProduced), 72'(8*(W-2) + 3 + EXP_WINS));
        checkOutput("errSofSet", 72'(err_sof), 72'(expErr));

        $display("[TB] reset mid row 20");
        sendFrame(20*W + 10, 1'b0, 1'b0);
        @(negedge clk);
        #3 rst = 1'b1;
        #1;
        checkOutput("midRstValid", 72'(m_valid), 72'(0));
        checkOutput("midRstErr",   72'(err_sof), 72'(0));
        checkOutput("midRstReady", 72'(s_ready), 72'(0));
        checkOutput("midRstLast",  72'(m_last),  72'(0));
        expQ.delete();
        mActive = 1'b0;
        expErr  = 1'b0;
        @(negedge clk);
        #3 rst = 1'b0;
        #1 checkOutput("readyAfterMidRst", 72'(s_ready), 72'(1));
        winCount = 0; mProduced = 0;
        sendFrame(W*H, 1'b0, 1'b1);
        waitDrain();
        checkOutput("postRstCount", 72'(winCount), 72'(EXP_WINS));
        checkOutput("postRstErr",   72'(err_sof),  72'(expErr));

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
